// File: rtl/fib_request_sequencer.sv
// Valid/ready request sequencer that steps a Fibonacci recurrence datapath and
// returns F(n) mod 2^W with a sticky overflow flag, at one or two steps per cycle.
module fib_request_sequencer #(
  parameter int unsigned W     = 16,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic             req_double,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_num,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [W-1:0]     a, b, a_d, b_d;
  logic             a_ovf, b_ovf, a_ovf_d, b_ovf_d;
  logic [IDX_W-1:0] remaining, remaining_d;
  logic             mode, mode_d;

  // sum1 = a+b; sum2 = (a+b)+b = a+2b, both with carry out for overflow tracking
  logic [W:0] sum1, sum2;
  assign sum1 = {1'b0, a} + {1'b0, b};
  assign sum2 = {1'b0, sum1[W-1:0]} + {1'b0, b};

  // Next-state and datapath
  always_comb begin
    state_d     = state;
    a_d         = a;
    b_d         = b;
    a_ovf_d     = a_ovf;
    b_ovf_d     = b_ovf;
    remaining_d = remaining;
    mode_d      = mode;

    case (state)
      IDLE: begin
        if (req_valid) begin
          a_d         = '0;
          b_d         = W'(1);
          a_ovf_d     = 1'b0;
          b_ovf_d     = 1'b0;
          remaining_d = req_index;
          mode_d      = req_double;
          state_d     = (req_index == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (mode && (remaining >= IDX_W'(2))) begin
          a_d         = sum1[W-1:0];
          a_ovf_d     = a_ovf | b_ovf | sum1[W];
          b_d         = sum2[W-1:0];
          b_ovf_d     = a_ovf | b_ovf | sum1[W] | sum2[W];
          remaining_d = remaining - IDX_W'(2);
        end else begin
          a_d         = b;
          a_ovf_d     = b_ovf;
          b_d         = sum1[W-1:0];
          b_ovf_d     = a_ovf | b_ovf | sum1[W];
          remaining_d = remaining - IDX_W'(1);
        end
        if (remaining_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other transition
    if (flush) begin
      state_d     = IDLE;
      remaining_d = '0;
      a_d         = '0;
      b_d         = '0;
      a_ovf_d     = 1'b0;
      b_ovf_d     = 1'b0;
    end
  end

  // State, datapath and handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      a_ovf     <= 1'b0;
      b_ovf     <= 1'b0;
      remaining <= '0;
      mode      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      a         <= a_d;
      b         <= b_d;
      a_ovf     <= a_ovf_d;
      b_ovf     <= b_ovf_d;
      remaining <= remaining_d;
      mode      <= mode_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == DONE);
      busy      <= (state_d == RUN) || (state_d == DONE);
    end
  end

  assign rsp_num = a;
  assign rsp_ovf = a_ovf;

endmodule
